// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial add/subtract sequencer that drives an external
// one-bit full-adder cell LSB first. Operands are loaded on start, one bit
// pair per clock is presented to the cell, and the returned sum bits are
// shifted into the result register. Carry-out and signed overflow are
// reported together with a one-cycle done pulse.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_c_msb;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_result;
    logic             r_busy;
    logic             r_done;

    // Sequencer FSM plus operand/result shift registers; subtraction is done
    // as A + ~B + 1 by inverting B at load time and seeding the carry with 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_c_msb  <= 1'b0;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sr  <= op_a;
                        r_b_sr  <= sub ? ~op_b : op_b;
                        r_carry <= sub;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_result <= {fa_sum, r_result[WIDTH-1:1]};
                    r_carry  <= fa_cout;
                    r_a_sr   <= r_a_sr >> 1;
                    r_b_sr   <= r_b_sr >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == LAST_BIT) begin
                        // carry presented to the MSB, needed for overflow
                        r_c_msb <= r_carry;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Full-adder drive comes straight from registers and is forced low
    // whenever the sequencer is not in RUN.
    assign fa_a   = r_a_sr[0] & r_busy;
    assign fa_b   = r_b_sr[0] & r_busy;
    assign fa_cin = r_carry   & r_busy;

    // The carry register is only touched in RUN or on an accepted start, so
    // cout/ovf stay valid from DONE until the next operation begins.
    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign cout   = r_carry;
    assign ovf    = r_c_msb ^ r_carry;

endmodule

// File: tb/tb_serial_add_seq.sv
// Bench for serial_add_seq: the full-adder cell is modelled combinationally,
// and every operation is checked cycle by cycle against arithmetic reference
// values (fa_* bit stream, busy/done timing, result/cout/ovf).
module tb_serial_add_seq;

    logic       clk = 1'b0;
    logic       rst, start, sub;
    logic [7:0] op_a, op_b;
    logic       fa_a, fa_b, fa_cin, fa_sum, fa_cout;
    logic       busy, done, cout, ovf;
    logic [7:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    serial_add_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub),
        .op_a(op_a), .op_b(op_b),
        .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
        .fa_sum(fa_sum), .fa_cout(fa_cout),
        .busy(busy), .done(done), .result(result),
        .cout(cout), .ovf(ovf)
    );

    // one-bit full-adder cell
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   busy,   0);
        chk({tag, "_done"},   done,   0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_fa_a"},   fa_a,   0);
        chk({tag, "_fa_b"},   fa_b,   0);
        chk({tag, "_fa_cin"}, fa_cin, 0);
        chk({tag, "_cout"},   cout,   0);
        chk({tag, "_ovf"},    ovf,    0);
    endtask

    // mode 0: plain; 1: extra start with na/nb/ns at RUN cycle 3;
    // 2: reset at RUN cycle 4; 3: start held into DONE with na/nb/ns.
    // Called and returns at a falling edge.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input int mode, input logic [7:0] na, input logic [7:0] nb,
                          input logic ns);
        logic [7:0] bb, exp_r;
        logic       exp_c, exp_v;
        logic       seen_done;
        int         sa, sb, sr, mask, pc;
        bb    = s ? ~b : b;
        exp_r = s ? (a - b) : (a + b);
        exp_c = s ? (a >= b) : ((int'(a) + int'(b)) > 255);
        sa    = int'($signed(a));
        sb    = int'($signed(b));
        sr    = s ? (sa - sb) : (sa + sb);
        exp_v = (sr > 127) || (sr < -128);
        seen_done = 1'b0;

        start = 1'b1; op_a = a; op_b = b; sub = s;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            chk("busy", busy, cyc < 8);
            chk("done", done, cyc == 8);
            if (cyc < 8) begin
                mask = (1 << cyc) - 1;
                pc   = ((int'(a) & mask) + (int'(bb) & mask) + int'(s)) >> cyc;
                chk("fa_a",   fa_a,   a[cyc]);
                chk("fa_b",   fa_b,   bb[cyc]);
                chk("fa_cin", fa_cin, pc & 1);
            end else begin
                chk("fa_idle", {fa_a, fa_b, fa_cin}, 0);
            end
            if (done) begin
                seen_done = 1'b1;
                chk("result", result, exp_r);
                chk("cout",   cout,   exp_c);
                chk("ovf",    ovf,    exp_v);
                if (mode == 3) begin
                    start = 1'b1; op_a = na; op_b = nb; sub = ns;
                    return;
                end
                @(negedge clk);
                chk("done_pulse",  done,   0);
                chk("result_hold", result, exp_r);
                chk("cout_hold",   cout,   exp_c);
                chk("ovf_hold",    ovf,    exp_v);
                return;
            end
            if (mode == 2 && cyc == 4) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                chk_all_zero("abort");
                repeat (12) begin
                    @(negedge clk);
                    chk("no_done_after_abort", done, 0);
                end
                return;
            end
            if (mode == 1 && cyc == 3) begin
                start = 1'b1; op_a = na; op_b = nb; sub = ns;
            end else begin
                start = 1'b0;
                op_a  = 8'($urandom);
                op_b  = 8'($urandom);
                sub   = 1'($urandom);
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", seen_done, 1);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rs;
        rst = 1'b1; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        run_op(8'h05, 8'h03, 1'b0, 0, 8'h00, 8'h00, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 8'h00, 8'h00, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 0, 8'h00, 8'h00, 1'b0);
        run_op(8'h05, 8'h07, 1'b1, 0, 8'h00, 8'h00, 1'b0);
        run_op(8'h80, 8'h01, 1'b1, 0, 8'h00, 8'h00, 1'b0);

        // start during RUN must be ignored
        run_op(8'h05, 8'h03, 1'b0, 1, 8'hAA, 8'h55, 1'b1);

        // back-to-back: start held through DONE
        run_op(8'h05, 8'h03, 1'b0, 3, 8'h10, 8'h20, 1'b0);
        run_op(8'h10, 8'h20, 1'b0, 0, 8'h00, 8'h00, 1'b0);

        // reset mid-RUN, then a fresh operation
        run_op(8'h05, 8'h03, 1'b0, 2, 8'h00, 8'h00, 1'b0);
        run_op(8'h05, 8'h03, 1'b0, 0, 8'h00, 8'h00, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rs = 1'($urandom);
            run_op(ra, rb, rs, 0, 8'h00, 8'h00, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
